// File: rtl/render_pkg.sv
// Shared geometry-pipeline types: datapath widths and the
// matrix_transform stage codes.
package render_pkg;

    localparam int DATA_W = 21;
    localparam int ACC_W  = 44;

    localparam logic [3:0] ST_IDLE   = 4'h0;
    localparam logic [3:0] ST_CLEAR  = 4'h1;
    localparam logic [3:0] ST_LOAD   = 4'h2;
    localparam logic [3:0] ST_MAC    = 4'h3;
    localparam logic [3:0] ST_DIVIDE = 4'h8;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_CLEAR  = ST_CLEAR,
        S_LOAD   = ST_LOAD,
        S_MAC    = ST_MAC,
        S_DIVIDE = ST_DIVIDE
    } mt_state_e;

endpackage

// File: rtl/matrix_transform_if.sv
// Request/result bundle between the geometry front end and
// the matrix_transform stage.
interface matrix_transform_if;
    import render_pkg::*;

    logic                       start;
    logic [16*DATA_W-1:0]       m_flat;
    logic [16*DATA_W-1:0]       v_flat;
    logic [3:0]                 matrix_state;
    logic                       busy;
    logic                       done;
    logic signed [DATA_W-1:0]   d11, d12, d13, d14;
    logic signed [DATA_W-1:0]   d21, d22, d23, d24;
    logic signed [DATA_W-1:0]   d31, d32, d33, d34;
    logic signed [DATA_W-1:0]   d41, d42, d43, d44;

    modport master (
        output start, m_flat, v_flat,
        input  matrix_state, busy, done,
        input  d11, d12, d13, d14, d21, d22, d23, d24,
        input  d31, d32, d33, d34, d41, d42, d43, d44
    );

    modport slave (
        input  start, m_flat, v_flat,
        output matrix_state, busy, done,
        output d11, d12, d13, d14, d21, d22, d23, d24,
        output d31, d32, d33, d34, d41, d42, d43, d44
    );

endinterface

// File: rtl/fixed_mac21.sv
// Signed Q-format multiply-accumulate with scaled 21-bit result.
// MATRIX_SAT_EN selects saturation instead of two's-complement wrap.
module fixed_mac21
    import render_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic                     restart_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic signed [DATA_W-1:0] res_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    shifted;

    assign prod    = a_i * b_i;
    assign base    = restart_i ? '0 : acc_i;
    assign acc_o   = base + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign shifted = acc_o >>> FRAC_BITS;

`ifdef MATRIX_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = -ACC_W'(1 << (DATA_W-1));

    always_comb begin
        res_o = shifted[DATA_W-1:0];
        if (shifted > MAX_V) begin
            res_o = MAX_V[DATA_W-1:0];
        end else if (shifted < MIN_V) begin
            res_o = MIN_V[DATA_W-1:0];
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shifted[ACC_W-1:DATA_W];
    assign res_o     = shifted[DATA_W-1:0];
`endif

endmodule

// File: rtl/matrix_transform.sv
// D = M x V on one shared MAC, then holds the result for the divide stage.
// Optional MATRIX_SAT_EN saturates results instead of wrapping.
module matrix_transform
    import render_pkg::*;
#(
    parameter int FRAC_BITS   = 8,
    parameter int DIVIDE_HOLD = 405
) (
    input  logic                CLK,
    input  logic                rst,
    matrix_transform_if.slave   io
);

    localparam logic [9:0] HOLD_LAST = 10'(DIVIDE_HOLD - 1);

    mt_state_e                state_q, state_d;
    logic [5:0]               step_q, step_d;
    logic [9:0]               hold_q, hold_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_n;
    logic signed [DATA_W-1:0] m_q [16];
    logic signed [DATA_W-1:0] m_d [16];
    logic signed [DATA_W-1:0] v_q [16];
    logic signed [DATA_W-1:0] v_d [16];
    logic signed [DATA_W-1:0] d_q [16];
    logic signed [DATA_W-1:0] d_d [16];
    logic signed [DATA_W-1:0] res;
    logic [1:0]               i_c, j_c, k_c;

    // step counter doubles as the i/j/k loop indices, k innermost
    assign i_c = step_q[5:4];
    assign j_c = step_q[3:2];
    assign k_c = step_q[1:0];

    fixed_mac21 #(.FRAC_BITS(FRAC_BITS)) u_mac (
        .a_i       (m_q[{i_c, k_c}]),
        .b_i       (v_q[{k_c, j_c}]),
        .acc_i     (acc_q),
        .restart_i (k_c == 2'd0),
        .acc_o     (acc_n),
        .res_o     (res)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        acc_d   = acc_q;
        m_d     = m_q;
        v_d     = v_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (io.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                for (int n = 0; n < 16; n++) d_d[n] = '0;
                acc_d   = '0;
                step_d  = '0;
                hold_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                for (int n = 0; n < 16; n++) begin
                    m_d[n] = io.m_flat[n*DATA_W +: DATA_W];
                    v_d[n] = io.v_flat[n*DATA_W +: DATA_W];
                end
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d  = acc_n;
                step_d = step_q + 6'd1;
                if (k_c == 2'd3) d_d[{i_c, j_c}] = res;
                if (step_q == 6'd63) state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                hold_d = hold_q + 10'd1;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            hold_q  <= '0;
            acc_q   <= '0;
            for (int n = 0; n < 16; n++) begin
                m_q[n] <= '0;
                v_q[n] <= '0;
                d_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            v_q     <= v_d;
            d_q     <= d_d;
        end
    end

    assign io.matrix_state = state_q;
    assign io.busy         = (state_q != S_IDLE);
    assign io.done         = (state_q == S_DIVIDE) && (hold_q == HOLD_LAST);

    assign io.d11 = d_q[0];
    assign io.d12 = d_q[1];
    assign io.d13 = d_q[2];
    assign io.d14 = d_q[3];
    assign io.d21 = d_q[4];
    assign io.d22 = d_q[5];
    assign io.d23 = d_q[6];
    assign io.d24 = d_q[7];
    assign io.d31 = d_q[8];
    assign io.d32 = d_q[9];
    assign io.d33 = d_q[10];
    assign io.d34 = d_q[11];
    assign io.d41 = d_q[12];
    assign io.d42 = d_q[13];
    assign io.d43 = d_q[14];
    assign io.d44 = d_q[15];

endmodule

// File: doc/matrix_transform.md
# matrix_transform

Upstream geometry stage that computes D = M × V for a 4×4 transform matrix M and a 4×4 vertex matrix V, whose columns are four homogeneous vertices (x, y, z, w). It uses one time-shared 21-bit signed fixed-point multiply-accumulate unit. It drives the clip-space result d11..d44 and the `matrix_state` code into the normalization (perspective-divide) stage. It holds state 8 ("divide") with stable outputs long enough for that stage to finish all eight divisions.

## Interface
- FRAC_BITS, 8, fractional bits of the Q-format; 1.0 = 256 by default.
- DIVIDE_HOLD, 405, number of cycles `matrix_state` stays at 8 (nine 45-cycle divider slots); legal range 1..1023.
- CLK  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a transform; accepted only in IDLE.
- m_flat  in  336  M, packed as Mij at bits [(4(i-1)+(j-1))*21 +: 21], signed.
- v_flat  in  336  V, same packing; column j is vertex j; rows are x, y, z, w.
- matrix_state  out  4  stage code: 0 idle, 1 clear, 2 load, 3 MAC, 8 divide.
- busy  out  1  high whenever matrix_state ≠ 0.
- done  out  1  one-cycle pulse on the last divide cycle.
- d11..d44  out  21 each  signed result; dij = Σk Mik·Vkj.

## Operation
- Reset: matrix_state=0, busy=0, done=0, all d=0, the accumulator and all counters are 0.
- IDLE (0): when start=1, go to CLEAR. Otherwise stay.
- CLEAR (1): one cycle. Zero all d registers and the accumulator. Go to LOAD.
- LOAD (2): one cycle. Capture m_flat and v_flat into internal operand registers. Inputs may change afterwards. Go to MAC.
- MAC (3): 64 cycles, one product per cycle.
  - Loop order is i outer, j middle, k inner, each from 1 to 4.
  - Next accumulator value: acc_n = (k==1 ? 0 : acc) + Mik·Vkj, computed in 44-bit signed arithmetic.
  - When k==4, scale acc_n and write it to dij.
  - After the (i=4, j=4, k=4) cycle, go to DIVIDE.
- DIVIDE (8): d outputs are held constant. A hold counter runs DIVIDE_HOLD cycles. done=1 in the final cycle, then go to IDLE.
- Codes 4–7 and 9–15 are unreachable. If any is entered, go to IDLE next cycle and leave the d registers untouched.
- Scaling: arithmetic right shift of acc_n by FRAC_BITS (rounds toward −∞), then narrow to 21 bits (see Configuration).
- start outside IDLE is ignored, with no queuing. start in the same cycle as DIVIDE's done is also ignored.
- rst in any state aborts the operation that cycle. Next cycle all outputs are at their reset values.
- d registers keep the last result through IDLE until the next CLEAR.

## Timing
- start sampled at edge t gives matrix_state: 1 at t+1, 2 at t+2, 3 for t+3..t+66, 8 from t+67.
- Entry n = 4(i-1)+(j-1) becomes valid at edge t+7+4n. d44 becomes valid at t+67, together with state 8.
- done is high in cycle t+66+DIVIDE_HOLD. matrix_state returns to 0 at t+67+DIVIDE_HOLD.
- Minimum start-to-start interval is 67+DIVIDE_HOLD+1 cycles.

## Configuration
- MATRIX_SAT_EN defined: the narrowed result saturates to [−1048576, 1048575].
- MATRIX_SAT_EN undefined: the narrowed result is the low 21 bits of the shifted value (two's-complement wrap).

## Structure
- Shared package `render_pkg` holds:
  - DATA_W=21 and ACC_W=44.
  - State constants ST_IDLE=4'h0, ST_CLEAR=4'h1, ST_LOAD=4'h2, ST_MAC=4'h3, ST_DIVIDE=4'h8.
  - A state enum typedef.
- Sub-module `fixed_mac21` contains the multiplier, accumulate-or-restart mux, shift, and saturate/wrap logic, parameterized by FRAC_BITS.
- The top level holds the FSM, the i/j/k counters, the hold counter, the operand registers and the d registers.

## Test plan
- Identity case: M = diag(256), V column 1 = (512, 768, 256, 256), other columns 0. Response: d11=512, d21=768, d31=256, d41=256, rest 0. matrix_state=8 exactly at t+67.
- Scale case: M = diag(512), all Vkj=300. Response: every dij=600. done pulses once at t+66+405. busy falls next cycle.
- Negative floor: M11=−1, V11=1, all else 0. Response: d11=−1 (not 0).
- Overflow case: M11=V11=1048575, rest 0.
  - With MATRIX_SAT_EN: d11=1048575.
  - With M11=−1048576: d11=−1048576.
  - Without the macro: d11 equals the low 21 bits of (product >>> 8).
- Abort and ignore: pulse start again at t+10 and confirm it is ignored with the result unchanged. Assert rst at t+30 (state 3): at t+31 matrix_state=0 and all d=0. A fresh start then yields the identity-case result.
